// File: rtl/lfa_arb_pkg.sv
// Shared configuration and types for the shared-adder arbiter slice.
package lfa_arb_pkg;

  localparam int unsigned LFA_W    = 14;
  localparam int unsigned LFA_NREQ = 4;
  localparam int unsigned LFA_IDW  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [LFA_IDW-1:0] id;
    logic [LFA_W:0]     sum;
  } rsp_t;

endpackage

// File: rtl/lfa_core_14.sv
// 14-bit prefix adder with carry-in; purely combinational.
// Carry-in is folded into bit 0's generate so the prefix tree yields every
// carry directly as the group generate of bits [i:0].
module lfa_core_14
  import lfa_arb_pkg::*;
(
  input  logic [LFA_W-1:0] a_i,
  input  logic [LFA_W-1:0] b_i,
  input  logic             cin_i,
  output logic [LFA_W-1:0] sum_o,
  output logic             cout_o
);

  logic [LFA_W-1:0] p0, g0, g1, p1, g2, p2, g3, p3, g4, p4;
  logic [LFA_W:0]   carry;

  // One prefix level: bits in the upper half of each 2^(lvl+1) block combine
  // with the top bit of the lower half.
  function automatic logic [2*LFA_W-1:0] lf_level(input logic [LFA_W-1:0] g,
                                                  input logic [LFA_W-1:0] p,
                                                  input int unsigned lvl);
    logic [LFA_W-1:0] go;
    logic [LFA_W-1:0] po;
    int unsigned      j;
    go = g;
    po = p;
    for (int unsigned i = 0; i < LFA_W; i++) begin
      if (((i >> lvl) & 1) == 1) begin
        j     = ((i >> lvl) << lvl) - 1;
        go[i] = g[i] | (p[i] & g[j]);
        po[i] = p[i] & p[j];
      end
    end
    return {go, po};
  endfunction

  // Bitwise generate/propagate, four prefix levels, then sum formation.
  always_comb begin
    p0    = a_i ^ b_i;
    g0    = a_i & b_i;
    g0[0] = (a_i[0] & b_i[0]) | (p0[0] & cin_i);
    {g1, p1} = lf_level(g0, p0, 0);
    {g2, p2} = lf_level(g1, p1, 1);
    {g3, p3} = lf_level(g2, p2, 2);
    {g4, p4} = lf_level(g3, p3, 3);
    carry  = {g4, cin_i};
    sum_o  = p0 ^ carry[LFA_W-1:0];
    cout_o = carry[LFA_W];
  end

endmodule

// File: rtl/lfa_add_arbiter.sv
// Round-robin arbiter sharing one prefix adder among NREQ requesters, with a
// single registered response slot that can drain and refill in one cycle.
module lfa_add_arbiter
  import lfa_arb_pkg::*;
#(
  parameter int unsigned NREQ = LFA_NREQ,
  parameter int unsigned W    = LFA_W,
  parameter int unsigned IDW  = LFA_IDW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_cin,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W:0]        rsp_sum,
  output logic [15:0]       busy_cnt
);

  state_t           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [W:0]       rsp_sum_q;
  logic [15:0]      busy_q;

  logic             slot_free;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic             grant;
  logic [W-1:0]     op_x;
  logic [W-1:0]     op_y;
  logic             op_cin;
  logic [W-1:0]     core_sum;
  logic             core_cout;
  int unsigned      idx;

  // Round-robin search from rr_ptr and operand selection for the winner.
  always_comb begin
    slot_free = (state_q == EMPTY) || rsp_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
    grant     = slot_free && gnt_found && !rst;
    req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
    op_x      = req_x[32'(gnt_idx)*W +: W];
    op_y      = req_y[32'(gnt_idx)*W +: W];
    op_cin    = req_cin[gnt_idx];
  end

  lfa_core_14 u_core (
    .a_i    (op_x),
    .b_i    (op_y),
    .cin_i  (op_cin),
    .sum_o  (core_sum),
    .cout_o (core_cout)
  );

  // Response-slot FSM, response register, rr pointer and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      rr_ptr_q  <= '0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      busy_q    <= '0;
    end else begin
      if (state_q == FULL && !rsp_ready && busy_q != 16'hFFFF) begin
        busy_q <= busy_q + 16'd1;
      end
      if (grant) begin
        state_q   <= FULL;
        rsp_id_q  <= gnt_idx;
        rsp_sum_q <= {core_cout, core_sum};
        rr_ptr_q  <= (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
      end else if (state_q == FULL && rsp_ready) begin
        state_q <= EMPTY;
      end
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_lfa_add_arbiter.sv
// Self-checking bench for lfa_add_arbiter: directed scenarios plus a random
// run against a transaction-level reference model and response scoreboard.
module tb_lfa_add_arbiter;

  localparam int N = 4;
  localparam int WD = 14;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*WD-1:0] req_x;
  logic [N*WD-1:0] req_y;
  logic [N-1:0]    req_cin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [WD:0]     rsp_sum;
  logic [15:0]     busy_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    int unsigned id;
    int unsigned sum;
  } exp_t;

  lfa_add_arbiter #(.NREQ(4), .W(14), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy_cnt  (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int unsigned x, input int unsigned y, input int unsigned c);
    req_x[i*WD +: WD] = WD'(x);
    req_y[i*WD +: WD] = WD'(y);
    req_cin[i]        = c[0];
  endtask

  function automatic int unsigned port_sum(input int i);
    return int'(req_x[i*WD +: WD]) + int'(req_y[i*WD +: WD]) + int'(req_cin[i]);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_x = '0; req_y = '0; req_cin = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 15'd0 || busy_cnt !== 16'd0 || req_ready !== 4'b0000) begin
      err_cnt++;
      $display("FAIL reset_state got v=%b id=%0d sum=%h busy=%0d rdy=%b want 0/0/0/0/0000",
               rsp_valid, rsp_id, rsp_sum, busy_cnt, req_ready);
    end
    tick();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_op(2, 32'h5, 32'h3, 1);
    req_valid = 4'b0100;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0100 || rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_grant got rdy=%b v=%b want 0100/0", req_ready, rsp_valid);
    end
    tick();
    req_valid = '0;
    #1;
    vec_cnt++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 15'h0009) begin
      err_cnt++;
      $display("FAIL single_rsp got v=%b id=%0d sum=%h want 1/2/0009", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
    #1;
    vec_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_drain got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_carry();
    rsp_ready = 1'b1;
    set_op(0, 32'h3FFF, 32'h0001, 0);
    req_valid = 4'b0001;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0001) begin
      err_cnt++;
      $display("FAIL carry_grant got rdy=%b want 0001", req_ready);
    end
    tick();
    set_op(0, 32'h3FFF, 32'h3FFF, 1);
    #1;
    vec_cnt++;
    if (rsp_sum !== 15'h4000 || rsp_id !== 2'd0 || req_ready !== 4'b0001) begin
      err_cnt++;
      $display("FAIL carry_out got sum=%h id=%0d rdy=%b want 4000/0/0001", rsp_sum, rsp_id, req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    vec_cnt++;
    if (rsp_sum !== 15'h7FFF || rsp_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL carry_max got sum=%h v=%b want 7fff/1", rsp_sum, rsp_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int unsigned exp_sum;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, $urandom);
    req_valid = 4'b1111;
    exp_sum = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      vec_cnt++;
      if (req_ready !== 4'(1 << (k % N))) begin
        err_cnt++;
        $display("FAIL rr_grant[%0d] got rdy=%b want %b", k, req_ready, 4'(1 << (k % N)));
      end
      if (k > 0) begin
        vec_cnt++;
        if (rsp_id !== 2'((k - 1) % N) || rsp_sum !== 15'(exp_sum) || rsp_valid !== 1'b1) begin
          err_cnt++;
          $display("FAIL rr_rsp[%0d] got id=%0d sum=%h want %0d/%h", k, rsp_id, rsp_sum, (k - 1) % N, 15'(exp_sum));
        end
      end
      exp_sum = port_sum(k % N);
      tick();
      set_op(k % N, $urandom, $urandom, $urandom);
    end
    req_valid = '0;
    #1;
    vec_cnt++;
    if (rsp_id !== 2'd1 || rsp_sum !== 15'(exp_sum)) begin
      err_cnt++;
      $display("FAIL rr_last got id=%0d sum=%h want 1/%h", rsp_id, rsp_sum, 15'(exp_sum));
    end
    tick();
  endtask

  task automatic test_backpressure();
    int unsigned s1;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom, $urandom);
    s1 = port_sum(1);
    req_valid = 4'b0010;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++;
      $display("FAIL bp_first got rdy=%b want 0010", req_ready);
    end
    tick();
    req_valid = 4'b1001;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vec_cnt++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 15'(s1)) begin
        err_cnt++;
        $display("FAIL bp_hold[%0d] got rdy=%b v=%b id=%0d sum=%h want 0000/1/1/%h",
                 k, req_ready, rsp_valid, rsp_id, rsp_sum, 15'(s1));
      end
      tick();
    end
    vec_cnt++;
    if (busy_cnt !== 16'd5) begin
      err_cnt++;
      $display("FAIL bp_busy got %0d want 5", busy_cnt);
    end
    rsp_ready = 1'b1;
    s1 = port_sum(3);
    #1;
    vec_cnt++;
    if (req_ready !== 4'b1000 || rsp_id !== 2'd1) begin
      err_cnt++;
      $display("FAIL bp_refill got rdy=%b id=%0d want 1000/1", req_ready, rsp_id);
    end
    tick();
    req_valid = 4'b0001;
    #1;
    vec_cnt++;
    if (rsp_id !== 2'd3 || rsp_sum !== 15'(s1) || req_ready !== 4'b0001 || busy_cnt !== 16'd5) begin
      err_cnt++;
      $display("FAIL bp_next got id=%0d sum=%h rdy=%b busy=%0d want 3/%h/0001/5",
               rsp_id, rsp_sum, req_ready, busy_cnt, 15'(s1));
    end
    s1 = port_sum(0);
    tick();
    req_valid = '0;
    #1;
    vec_cnt++;
    if (rsp_id !== 2'd0 || rsp_sum !== 15'(s1)) begin
      err_cnt++;
      $display("FAIL bp_port0 got id=%0d sum=%h want 0/%h", rsp_id, rsp_sum, 15'(s1));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    vec_cnt++;
    if (req_ready !== 4'b0100) begin
      err_cnt++;
      $display("FAIL rmid_grant got rdy=%b want 0100", req_ready);
    end
    tick();
    tick();
    req_valid = 4'b1100;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1010;
    #1;
    vec_cnt++;
    if (rsp_valid !== 1'b0 || busy_cnt !== 16'd0 || req_ready !== 4'b0010) begin
      err_cnt++;
      $display("FAIL rmid_after got v=%b busy=%0d rdy=%b want 0/0/0010", rsp_valid, busy_cnt, req_ready);
    end
    tick();
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    int           wait_n [N];
    exp_t         q [$];
    exp_t         e;
    bit           m_full;
    int           m_ptr;
    int unsigned  m_busy;
    int           eg;
    logic [N-1:0] exp_rdy;
    bit           slot;
    int           hs;
    do_reset();
    pend = '0;
    m_full = 0; m_ptr = 0; m_busy = 0;
    for (int i = 0; i < N; i++) wait_n[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 2) == 1) begin
          pend[i] = 1'b1;
          set_op(i, $urandom, $urandom, $urandom);
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom % 4) != 0;
      #1;
      slot = !m_full || rsp_ready;
      eg = -1;
      for (int k = 0; k < N; k++) begin
        if (eg < 0 && pend[(m_ptr + k) % N]) eg = (m_ptr + k) % N;
      end
      exp_rdy = (slot && eg >= 0) ? 4'(1 << eg) : 4'b0000;
      vec_cnt++;
      if (req_ready !== exp_rdy || rsp_valid !== m_full || busy_cnt !== 16'(m_busy)) begin
        err_cnt++;
        $display("FAIL rand_cycle[%0d] got rdy=%b v=%b busy=%0d want %b/%b/%0d",
                 cyc, req_ready, rsp_valid, busy_cnt, exp_rdy, m_full, m_busy);
      end
      if (rsp_valid && rsp_ready) begin
        vec_cnt++;
        if (q.size() == 0) begin
          err_cnt++;
          $display("FAIL rand_spurious[%0d] got id=%0d sum=%h want no response", cyc, rsp_id, rsp_sum);
        end else begin
          e = q.pop_front();
          if (rsp_id !== 2'(e.id) || rsp_sum !== 15'(e.sum)) begin
            err_cnt++;
            $display("FAIL rand_rsp[%0d] got id=%0d sum=%h want %0d/%h", cyc, rsp_id, rsp_sum, e.id, 15'(e.sum));
          end
        end
      end
      hs = -1;
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) hs = i;
      if (hs >= 0) begin
        e.id = hs;
        e.sum = port_sum(hs);
        q.push_back(e);
        vec_cnt++;
        if (wait_n[hs] > N - 1) begin
          err_cnt++;
          $display("FAIL rand_fair[%0d] port %0d waited %0d grants, want <= %0d", cyc, hs, wait_n[hs], N - 1);
        end
        for (int i = 0; i < N; i++) if (pend[i] && i != hs) wait_n[i]++;
        wait_n[hs] = 0;
        pend[hs] = 1'b0;
      end
      if (m_full && !rsp_ready && m_busy < 32'hFFFF) m_busy++;
      if (slot && eg >= 0) begin
        m_full = 1;
        m_ptr = (eg + 1) % N;
      end else if (m_full && rsp_ready) begin
        m_full = 0;
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    if (rsp_valid) begin
      vec_cnt++;
      if (q.size() == 0) begin
        err_cnt++;
        $display("FAIL rand_drain got id=%0d sum=%h want no response", rsp_id, rsp_sum);
      end else begin
        e = q.pop_front();
        if (rsp_id !== 2'(e.id) || rsp_sum !== 15'(e.sum)) begin
          err_cnt++;
          $display("FAIL rand_drain got id=%0d sum=%h want %0d/%h", rsp_id, rsp_sum, e.id, 15'(e.sum));
        end
      end
    end
    tick();
    vec_cnt++;
    if (rsp_valid !== 1'b0 || q.size() != 0) begin
      err_cnt++;
      $display("FAIL rand_end got v=%b outstanding=%0d want 0/0", rsp_valid, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
